// File: rtl/imem_load_arbiter_if.sv
// Bundles the loader stream, CPU fetch port and byte-wide memory port of the
// instruction-memory arbiter. slave = the arbiter, master = the surrounding system.
interface imem_load_arbiter_if;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_inst;
    logic        cpu_reset;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] words_loaded;
    logic        load_err;
    logic        fetch_err;

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, cpu_pc, mem_rdata,
        output ld_ready, cpu_inst, cpu_reset, mem_addr, mem_we, mem_wdata,
               words_loaded, load_err, fetch_err
    );

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, cpu_pc, mem_rdata,
        input  ld_ready, cpu_inst, cpu_reset, mem_addr, mem_we, mem_wdata,
               words_loaded, load_err, fetch_err
    );
endinterface

// File: rtl/imem_load_arbiter.sv
// Shares the byte-wide instruction memory between a word loader (big-endian byte writes)
// and the CPU fetch port. Optional macro IMEM_FETCH_GUARD_EN enables fetch range/alignment checks.
module imem_load_arbiter #(
    parameter int MEM_SIZE = 512,
    parameter int EXC_ADDR = MEM_SIZE - 120,
    parameter int RST_HOLD = 4
) (
    input logic                clk,
    input logic                reset,
    imem_load_arbiter_if.slave bus
);
    localparam int HCW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_WRITE,
        S_HOLD,
        S_RUN
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_wptr;
    logic [31:0]     r_word;
    logic            r_last;
    logic [1:0]      r_k;
    logic [HCW-1:0]  r_hold_cnt;
    logic [15:0]     r_words;
    logic            r_load_err;

    logic            w_start;
    logic            w_accept;
    logic            w_fits;
    logic [7:0]      w_bytes [4];

    logic            w_ld_ready;
    logic            w_cpu_reset;
    logic            w_mem_we;
    logic [31:0]     w_mem_addr;
    logic [7:0]      w_mem_wdata;
    logic [31:0]     w_cpu_inst;
    logic            w_fetch_err;

    // Byte k of the latched word, MSB first, so byte 0 lands at the lowest address
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign w_bytes[gi] = r_word[31-8*gi -: 8];
        end
    endgenerate

    assign w_start  = ((r_state == S_IDLE) || (r_state == S_RUN)) && bus.ld_start;
    assign w_accept = (r_state == S_LOAD_WAIT) && bus.ld_valid;
    assign w_fits   = (r_wptr + 32'd4) <= 32'(EXC_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ld_ready   = 1'b0;
        w_cpu_reset  = 1'b1;
        w_mem_we     = 1'b0;
        w_mem_addr   = 32'd0;
        w_mem_wdata  = 8'd0;
        w_cpu_inst   = 32'd0;
        w_fetch_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ld_start) w_state_next = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                w_ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    if (w_fits)           w_state_next = S_WRITE;
                    else if (bus.ld_last) w_state_next = S_HOLD;
                end
            end
            S_WRITE: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_wptr + {30'd0, r_k};
                w_mem_wdata = w_bytes[r_k];
                if (r_k == 2'd3) w_state_next = r_last ? S_HOLD : S_LOAD_WAIT;
            end
            S_HOLD: begin
                if (r_hold_cnt == HCW'(RST_HOLD - 1)) w_state_next = S_RUN;
            end
            S_RUN: begin
                w_cpu_reset = 1'b0;
`ifdef IMEM_FETCH_GUARD_EN
                if ((bus.cpu_pc[1:0] != 2'b00) || (bus.cpu_pc > 32'(MEM_SIZE - 4))) begin
                    w_fetch_err = 1'b1;
                end else begin
                    w_mem_addr = bus.cpu_pc;
                    w_cpu_inst = bus.mem_rdata;
                end
`else
                w_mem_addr = bus.cpu_pc % 32'(MEM_SIZE);
                w_cpu_inst = bus.mem_rdata;
`endif
                if (bus.ld_start) w_state_next = S_LOAD_WAIT;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= 32'd0;
            r_word     <= 32'd0;
            r_last     <= 1'b0;
            r_k        <= 2'd0;
            r_hold_cnt <= '0;
            r_words    <= 16'd0;
            r_load_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_wptr     <= 32'd0;
                r_words    <= 16'd0;
                r_load_err <= 1'b0;
                r_k        <= 2'd0;
            end
            if (w_accept) begin
                r_word <= bus.ld_data;
                r_last <= bus.ld_last;
                r_k    <= 2'd0;
                if (!w_fits) r_load_err <= 1'b1;
            end
            if (r_state == S_WRITE) begin
                r_k <= r_k + 2'd1;
                if (r_k == 2'd3) begin
                    r_wptr <= r_wptr + 32'd4;
                    if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
                end
            end
            r_hold_cnt <= (r_state == S_HOLD) ? r_hold_cnt + HCW'(1) : '0;
        end
    end

    assign bus.ld_ready     = w_ld_ready;
    assign bus.cpu_reset    = w_cpu_reset;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_wdata    = w_mem_wdata;
    assign bus.cpu_inst     = w_cpu_inst;
    assign bus.fetch_err    = w_fetch_err;
    assign bus.words_loaded = r_words;
    assign bus.load_err     = r_load_err;
endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: byte-memory model, loader stream and fetch checks.
module tb_imem_load_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic mem_clr;
    int   checks = 0;
    int   errors = 0;

    imem_load_arbiter_if bus ();

    imem_load_arbiter #(.MEM_SIZE(512), .EXC_ADDR(392), .RST_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Byte-wide memory model with combinational 4-byte big-endian read
    logic [7:0] mem [0:511];
    logic [8:0] ra;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'hEE;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[8:0]] <= bus.mem_wdata;
        end
    end
    always_comb begin
        ra = bus.mem_addr[8:0];
        bus.mem_rdata = {mem[ra], mem[ra + 9'd1], mem[ra + 9'd2], mem[ra + 9'd3]};
    end

    task automatic test_reset();
        reset = 1'b0; mem_clr = 1'b1;
        bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 32'd0;
        bus.ld_last = 1'b0; bus.cpu_pc = 32'd0;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        #1;
        checks++; if (bus.cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b exp 1", bus.cpu_reset); end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready got %b exp 0", bus.ld_ready); end
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 8'd0) begin
            errors++; $display("FAIL rst_mem got we=%b a=%h d=%h exp 0/0/0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.words_loaded !== 16'd0 || bus.load_err !== 1'b0 || bus.fetch_err !== 1'b0) begin
            errors++; $display("FAIL rst_status got wl=%h le=%b fe=%b exp 0/0/0", bus.words_loaded, bus.load_err, bus.fetch_err); end
        checks++; if (bus.cpu_inst !== 32'd0) begin errors++; $display("FAIL rst_cpu_inst got %h exp 0", bus.cpu_inst); end
        @(negedge clk);
        reset = 1'b1;
        bus.ld_valid = 1'b1; bus.ld_data = 32'h12345678;
        #1;
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL idle_ld_ready got %b exp 0", bus.ld_ready); end
        @(negedge clk);
        bus.ld_valid = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.words_loaded !== 16'd0) begin
            errors++; $display("FAIL idle_ignore_valid got we=%b wl=%h exp 0/0", bus.mem_we, bus.words_loaded); end
    endtask

    task automatic test_single_load();
        logic [7:0] eb [4];
        eb[0] = 8'h20; eb[1] = 8'h05; eb[2] = 8'h00; eb[3] = 8'h05;
        @(negedge clk); bus.ld_start = 1'b1;
        @(negedge clk); bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 32'h20050005; bus.ld_last = 1'b1;
        #1;
        checks++; if (bus.ld_ready !== 1'b1 || bus.cpu_reset !== 1'b1) begin
            errors++; $display("FAIL lw_ready got rdy=%b cr=%b exp 1/1", bus.ld_ready, bus.cpu_reset); end
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_data = 32'd0; bus.ld_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'(k) || bus.mem_wdata !== eb[k] || bus.ld_ready !== 1'b0) begin
                errors++; $display("FAIL write_byte%0d got we=%b a=%h d=%h rdy=%b exp 1/%h/%h/0",
                                   k, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.ld_ready, k, eb[k]); end
            if (k < 3) @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++; if (bus.cpu_reset !== 1'b1 || bus.mem_we !== 1'b0) begin
                errors++; $display("FAIL hold%0d got cr=%b we=%b exp 1/0", i, bus.cpu_reset, bus.mem_we); end
        end
        @(negedge clk); #1;
        checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("FAIL run_cpu_reset got %b exp 0", bus.cpu_reset); end
        checks++; if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h20050005) begin
            errors++; $display("FAIL single_mem got %h exp 20050005", {mem[0], mem[1], mem[2], mem[3]}); end
        checks++; if (bus.words_loaded !== 16'd1) begin errors++; $display("FAIL single_words got %h exp 1", bus.words_loaded); end
        bus.cpu_pc = 32'd0; #1;
        checks++; if (bus.cpu_inst !== 32'h20050005 || bus.mem_addr !== 32'd0) begin
            errors++; $display("FAIL fetch0 got inst=%h a=%h exp 20050005/0", bus.cpu_inst, bus.mem_addr); end
        bus.cpu_pc = 32'd4; #1;
        checks++; if (bus.cpu_inst !== 32'hEEEEEEEE || bus.mem_addr !== 32'd4) begin
            errors++; $display("FAIL fetch4 got inst=%h a=%h exp eeeeeeee/4", bus.cpu_inst, bus.mem_addr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w3 [3];
        int to;
        w3[0] = 32'h11223344; w3[1] = 32'h55667788; w3[2] = 32'h99AABBCC;
        @(negedge clk); bus.ld_start = 1'b1;
        @(negedge clk); bus.ld_start = 1'b0;
        #1;
        checks++; if (bus.cpu_reset !== 1'b1 || bus.words_loaded !== 16'd0) begin
            errors++; $display("FAIL restart_from_run got cr=%b wl=%h exp 1/0", bus.cpu_reset, bus.words_loaded); end
        bus.ld_valid = 1'b1;
        for (int c = 0; c < 15; c++) begin
            bus.ld_data = w3[c/5]; bus.ld_last = (c / 5 == 2);
            #1;
            checks++; if (bus.ld_ready !== ((c % 5) == 0)) begin
                errors++; $display("FAIL b2b_ready_c%0d got %b exp %b", c, bus.ld_ready, ((c % 5) == 0)); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.ld_ready !== 1'b0 || bus.words_loaded !== 16'd3) begin
            errors++; $display("FAIL b2b_hold got rdy=%b wl=%h exp 0/3", bus.ld_ready, bus.words_loaded); end
        to = 0;
        while (bus.cpu_reset !== 1'b0 && to < 10) begin @(negedge clk); #1; to++; end
        checks++; if (to !== 4) begin errors++; $display("FAIL b2b_hold_len got %0d exp 4", to); end
        checks++; if (bus.ld_ready !== 1'b0 || bus.words_loaded !== 16'd3) begin
            errors++; $display("FAIL b2b_run_ignore got rdy=%b wl=%h exp 0/3", bus.ld_ready, bus.words_loaded); end
        for (int w = 0; w < 3; w++) begin
            checks++; if ({mem[4*w], mem[4*w+1], mem[4*w+2], mem[4*w+3]} !== w3[w]) begin
                errors++; $display("FAIL b2b_mem%0d got %h exp %h", w,
                                   {mem[4*w], mem[4*w+1], mem[4*w+2], mem[4*w+3]}, w3[w]); end
        end
        bus.cpu_pc = 32'd8; #1;
        checks++; if (bus.cpu_inst !== 32'h99AABBCC) begin errors++; $display("FAIL b2b_fetch8 got %h exp 99aabbcc", bus.cpu_inst); end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    endtask

    task automatic test_overflow();
        int to;
        @(negedge clk); bus.ld_start = 1'b1;
        @(negedge clk); bus.ld_start = 1'b0;
        for (int i = 0; i < 99; i++) begin
            to = 0;
            #1;
            while (bus.ld_ready !== 1'b1 && to < 20) begin @(negedge clk); #1; to++; end
            if (to >= 20) begin
                checks++; errors++; $display("FAIL ovf_ready_timeout word %0d got 0 exp 1", i);
                break;
            end
            if (i == 98) begin
                checks++; if (bus.load_err !== 1'b0 || bus.words_loaded !== 16'd98) begin
                    errors++; $display("FAIL ovf_pre got le=%b wl=%h exp 0/62", bus.load_err, bus.words_loaded); end
            end
            bus.ld_valid = 1'b1; bus.ld_data = 32'hC0DE0000 | 32'(i); bus.ld_last = (i == 98);
            @(negedge clk);
            bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        end
        #1;
        checks++; if (bus.load_err !== 1'b1 || bus.words_loaded !== 16'd98 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL ovf_drop got le=%b wl=%h we=%b exp 1/62/0", bus.load_err, bus.words_loaded, bus.mem_we); end
        checks++; if ({mem[388], mem[389], mem[390], mem[391]} !== 32'hC0DE0061 ||
                      {mem[392], mem[393], mem[394], mem[395]} !== 32'hEEEEEEEE) begin
            errors++; $display("FAIL ovf_mem got %h %h exp c0de0061 eeeeeeee",
                               {mem[388], mem[389], mem[390], mem[391]}, {mem[392], mem[393], mem[394], mem[395]}); end
        to = 0;
        while (bus.cpu_reset !== 1'b0 && to < 10) begin @(negedge clk); #1; to++; end
        checks++; if (bus.cpu_reset !== 1'b0) begin errors++; $display("FAIL ovf_run got cr=%b exp 0", bus.cpu_reset); end
        bus.cpu_pc = 32'd388; #1;
        checks++; if (bus.cpu_inst !== 32'hC0DE0061) begin errors++; $display("FAIL ovf_fetch got %h exp c0de0061", bus.cpu_inst); end
    endtask

    task automatic test_reset_mid_write();
        int to;
        @(negedge clk); bus.ld_start = 1'b1;
        @(negedge clk); bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 32'hA1B2C3D4; bus.ld_last = 1'b1;
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 8'd0 || bus.cpu_reset !== 1'b1) begin
            errors++; $display("FAIL midrst_outputs got we=%b a=%h d=%h cr=%b exp 0/0/0/1",
                               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_reset); end
        checks++; if (bus.words_loaded !== 16'd0 || bus.load_err !== 1'b0 || bus.ld_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_status got wl=%h le=%b rdy=%b exp 0/0/0", bus.words_loaded, bus.load_err, bus.ld_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        checks++; if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hA1DE0000) begin
            errors++; $display("FAIL midrst_mem got %h exp a1de0000", {mem[0], mem[1], mem[2], mem[3]}); end
        bus.ld_start = 1'b1;
        @(negedge clk); bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 32'h0BADF00D; bus.ld_last = 1'b1;
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        to = 0; #1;
        while (bus.cpu_reset !== 1'b0 && to < 20) begin @(negedge clk); #1; to++; end
        checks++; if (bus.cpu_reset !== 1'b0 || bus.words_loaded !== 16'd1) begin
            errors++; $display("FAIL midrst_reload got cr=%b wl=%h exp 0/1", bus.cpu_reset, bus.words_loaded); end
        bus.cpu_pc = 32'd0; #1;
        checks++; if (bus.cpu_inst !== 32'h0BADF00D) begin errors++; $display("FAIL midrst_fetch got %h exp 0badf00d", bus.cpu_inst); end
    endtask

    task automatic test_fetch_guard();
`ifdef IMEM_FETCH_GUARD_EN
        bus.cpu_pc = 32'd2; #1;
        checks++; if (bus.cpu_inst !== 32'd0 || bus.fetch_err !== 1'b1 || bus.mem_addr !== 32'd0) begin
            errors++; $display("FAIL guard_pc2 got inst=%h fe=%b a=%h exp 0/1/0", bus.cpu_inst, bus.fetch_err, bus.mem_addr); end
        bus.cpu_pc = 32'd510; #1;
        checks++; if (bus.cpu_inst !== 32'd0 || bus.fetch_err !== 1'b1 || bus.mem_addr !== 32'd0) begin
            errors++; $display("FAIL guard_pc510 got inst=%h fe=%b a=%h exp 0/1/0", bus.cpu_inst, bus.fetch_err, bus.mem_addr); end
        bus.cpu_pc = 32'd0; #1;
        checks++; if (bus.cpu_inst !== 32'h0BADF00D || bus.fetch_err !== 1'b0) begin
            errors++; $display("FAIL guard_pc0 got inst=%h fe=%b exp 0badf00d/0", bus.cpu_inst, bus.fetch_err); end
`else
        bus.cpu_pc = 32'd514; #1;
        checks++; if (bus.mem_addr !== 32'd2 || bus.cpu_inst !== 32'hF00DC0DE || bus.fetch_err !== 1'b0) begin
            errors++; $display("FAIL wrap_pc514 got a=%h inst=%h fe=%b exp 2/f00dc0de/0", bus.mem_addr, bus.cpu_inst, bus.fetch_err); end
        bus.cpu_pc = 32'd510; #1;
        checks++; if (bus.mem_addr !== 32'd510 || bus.fetch_err !== 1'b0) begin
            errors++; $display("FAIL nowrap_pc510 got a=%h fe=%b exp 1fe/0", bus.mem_addr, bus.fetch_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_back_to_back();
        test_overflow();
        test_reset_mid_write();
        test_fetch_guard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
